lcm_job_dispatcher: RTL
=======================

// Module: lcm_job_dispatcher
// PURPOSE
//  Upstream feeder stage for the LCM core.
//  Accepts tagged operand pairs over a valid/ready input and buffers them in a small FIFO.
//  Launches one core job at a time and returns each result, with its tag, over a valid/ready output.
//  Screens out zero operands so the core never performs a modulo by zero.
//  A watchdog guards against a core that never completes.
// PARAMETERS
//  W        32   operand/result width
//  TW       4    tag width
//  DEPTH    4    input FIFO depth, power of 2, >=2
//  TIMEOUT  4096 max cycles in WAIT before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  in_valid     in   1   operand pair offered
//  in_ready     out  1   FIFO can accept; = !full
//  in_a         in   W   operand A
//  in_b         in   W   operand B
//  in_tag       in   TW  job tag, returned unchanged
//  core_start   out  1   one-cycle launch pulse to LCM core
//  core_n1      out  W   max(a,b); stable from LAUNCH until job ends
//  core_n2      out  W   min(a,b); stable from LAUNCH until job ends
//  core_done    in   1   core result valid, sampled in WAIT only
//  core_result  in   W   core LCM value
//  out_valid    out  1   result offered
//  out_ready    in   1   consumer accepts
//  out_result   out  W   LCM; 0 for zero or error jobs
//  out_tag      out  TW  tag of the job
//  out_zero     out  1   job had a zero operand, core not used
//  out_err      out  1   job aborted by watchdog
//  busy         out  1   FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset: FIFO emptied; state IDLE.
//   All outputs 0, except in_ready=1.
//   Core is reset on the same rst.
//  FIFO
//   Push on in_valid&&in_ready.
//   Push and pop in the same cycle are both allowed when 1<=count<DEPTH.
//   When full, in_ready=0 even if a pop occurs this cycle (no pop-aware ready).
//   Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
//  FSM {IDLE, LAUNCH, WAIT, EMIT}
//   IDLE
//    If FIFO not empty: pop head into job regs.
//    If a==0 or b==0: go to EMIT with result=0, zero=1.
//    Otherwise: go to LAUNCH.
//   LAUNCH
//    core_start=1 for exactly this cycle.
//    core_n1/core_n2 are driven from the job regs.
//    Clear the watchdog; go to WAIT.
//   WAIT
//    core_done=1: capture core_result; go to EMIT.
//    Else if watchdog==TIMEOUT-1: result=0, err=1; go to EMIT.
//    Else: increment the watchdog.
//   EMIT
//    out_valid=1; all out_* fields are held stable.
//    On out_ready: go to IDLE. The next job may be popped in the following cycle.
//  Latency
//   Zero-operand job: pop -> out_valid in 1 cycle.
//   Normal job: pop -> core_start in 1 cycle; core_done -> out_valid in 1 cycle.
//  out_zero and out_err are mutually exclusive.
//  out_* are registered; no combinational path from in_* or core_* to out_*.
//  Equal operands: n1=n2=a.
//  core_done outside WAIT is ignored.
//  rst mid-job: the job is discarded and no output is produced.
// STRUCTURE
//  Package lcm_pkg:
//   state enum (2 bits: IDLE=0, LAUNCH=1, WAIT=2, EMIT=3)
//   default W/TW constants
//  Sub-module lcm_job_fifo:
//   parameterised sync FIFO {tag,a,b}, width W*2+TW
//   outputs full/empty/count
//  The top level holds the FSM, the operand sort, the watchdog and the output regs.
// TESTING
//  1. Push (12,18,tag3).
//     Required: core_n1=18, core_n2=12, one core_start pulse.
//     Model returns 36 -> out_result=36, out_tag=3, zero=0, err=0.
//  2. Push (0,7,tag1).
//     Required: no core_start; out_valid 1 cycle after pop; result=0, out_zero=1.
//  3. Hold the core busy and push 5 pairs with DEPTH=4.
//     Required: in_ready=0 after 4 accepted; 5th accepted after first pop.
//     Tags emerge in order.
//  4. Hold out_ready=0 for 10 cycles in EMIT.
//     Required: out_valid and fields stable; no new core_start until the handshake.
//  5. Core never asserts done, TIMEOUT=16.
//     Required: out_err=1, result=0 exactly 16 cycles after entering WAIT.
//     The next queued job then launches normally.
//  6. Assert rst during WAIT with 2 jobs queued.
//     Required: next cycle busy=0, in_ready=1, out_valid=0, no output for the dropped jobs.

Source files
------------

// File: rtl/lcm_pkg.sv
// Shared types and default widths for the LCM job dispatcher slice.
// Holds the dispatcher FSM encoding and the default operand and tag widths.
package lcm_pkg;

    localparam int W_DEF  = 32;
    localparam int TW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

endpackage

// File: rtl/lcm_job_fifo.sv
// Synchronous FIFO for {tag,a,b} job entries.
// Head entry visible combinationally on pop_dat; push/pop take effect on the next edge.
// Pushes while full and pops while empty are ignored; the writer watches full.
module lcm_job_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/lcm_job_dispatcher.sv
// Feeds tagged operand pairs to the LCM core one job at a time and returns tagged results.
// Latency: pop->core_start 1 cycle (zero job: pop->out_valid 1 cycle); core_done->out_valid 1 cycle.
// Backpressure: in_ready = FIFO not full; a result is held in EMIT until out_ready.
module lcm_job_dispatcher
    import lcm_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TW      = TW_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [TW-1:0] in_tag,
    output logic          core_start,
    output logic [W-1:0]  core_n1,
    output logic [W-1:0]  core_n2,
    input  logic          core_done,
    input  logic [W-1:0]  core_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [TW-1:0] out_tag,
    output logic          out_zero,
    output logic          out_err,
    output logic          busy
);

    localparam int FW  = 2*W + TW;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WDW = $clog2(TIMEOUT+1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT-1);

    state_t          state;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [FW-1:0]   fifo_head;
    logic            fifo_pop;
    logic [W-1:0]    head_a;
    logic [W-1:0]    head_b;
    logic [TW-1:0]   head_tag;
    logic            head_zero;
    logic [TW-1:0]   job_tag;
    logic [WDW-1:0]  wd;

    lcm_job_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid && in_ready),
        .push_dat ({in_tag, in_a, in_b}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign {head_tag, head_a, head_b} = fifo_head;
    assign head_zero = (head_a == '0) || (head_b == '0);
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            core_start <= 1'b0;
            core_n1    <= '0;
            core_n2    <= '0;
            job_tag    <= '0;
            wd         <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        // Sorted so the core always divides the larger by the smaller.
                        core_n1 <= (head_a >= head_b) ? head_a : head_b;
                        core_n2 <= (head_a >= head_b) ? head_b : head_a;
                        job_tag <= head_tag;
                        if (head_zero) begin
                            out_valid  <= 1'b1;
                            out_result <= '0;
                            out_tag    <= head_tag;
                            out_zero   <= 1'b1;
                            out_err    <= 1'b0;
                            state      <= ST_EMIT;
                        end else begin
                            core_start <= 1'b1;
                            state      <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        out_valid  <= 1'b1;
                        out_result <= core_result;
                        out_tag    <= job_tag;
                        out_zero   <= 1'b0;
                        out_err    <= 1'b0;
                        state      <= ST_EMIT;
                    end else if (wd == WD_LAST) begin
                        out_valid  <= 1'b1;
                        out_result <= '0;
                        out_tag    <= job_tag;
                        out_zero   <= 1'b0;
                        out_err    <= 1'b1;
                        state      <= ST_EMIT;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
